// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states and alignment check
// shared by the load/store front end and its lane aligner.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    return (size == SZ_X)
         | ((size == SZ_H) & addr[0])
         | ((size == SZ_W) & (addr != 2'b00));
  endfunction

endpackage

// File: rtl/SP_SRAM.sv
// SP_SRAM: single-port word SRAM, byte-enabled writes, one-cycle
// registered read. Ports: CLK, CSN, WEN, ADDR, BE, DI, DOUT.
module SP_SRAM #(
  parameter int AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              CSN,
  input  logic              WEN,
  input  logic [AWIDTH-1:0] ADDR,
  input  logic [3:0]        BE,
  input  logic [31:0]       DI,
  output logic [31:0]       DOUT
);

  logic [31:0] mem_q [2**AWIDTH];

  always_ff @(posedge CLK) begin
    if (!CSN) begin
      if (!WEN) begin
        for (int i = 0; i < 4; i++) begin
          if (BE[i]) mem_q[ADDR][8*i +: 8] <= DI[8*i +: 8];
        end
      end else begin
        DOUT <= mem_q[ADDR];
      end
    end
  end

endmodule

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half lane of a read word
// and sign/zero-extends it. In: word, addr, size, uns. Out: data.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted = word >> {addr, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    unique case (size)
      SZ_B: data = uns ? {24'h0, lane_b}
                       : {{24{lane_b[7]}}, lane_b};
      SZ_H: data = uns ? {16'h0, lane_h}
                       : {{16{lane_h[15]}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store requests -> word SRAM
// accesses (CSN/WEN/ADDR/BE/DI), load lane extraction, RESP pulse.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RESP_VALID,
  output logic [31:0]       RESP_RDATA,
  output logic              RESP_ERR,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  state_e state_q, state_d;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [AWIDTH+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        accept;
  logic        req_err;
  logic        in_access;
  logic [31:0] load_data;

  // Address bits above the SRAM range alias and are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^REQ_ADDR[31:AWIDTH+2];

  assign REQ_READY = (state_q == ST_IDLE) & ~RST;
  assign accept    = REQ_VALID & REQ_READY;
  assign req_err   = misaligned(REQ_SIZE, REQ_ADDR[1:0]);
  assign in_access = (state_q == ST_ACCESS);

  mem_load_align u_align (
    .word (MEM_DOUT),
    .addr (addr_q[1:0]),
    .size (size_q),
    .uns  (uns_q),
    .data (load_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = REQ_WE;
          size_d  = REQ_SIZE;
          uns_d   = REQ_UNSIGNED;
          addr_d  = REQ_ADDR[AWIDTH+1:0];
          wdata_d = REQ_WDATA;
          if (req_err) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = 32'h0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        err_d   = 1'b0;
        rdata_d = load_data;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RST gates the select so an aborted store never reaches the array.
  assign MEM_CSN  = ~(in_access & ~RST);
  assign MEM_WEN  = in_access ? ~we_q : 1'b1;
  assign MEM_ADDR = addr_q[AWIDTH+1:2];

  always_comb begin
    MEM_BE = 4'b0000;
    MEM_DI = 32'h0;
    if (in_access) begin
      unique case (size_q)
        SZ_B: begin
          MEM_BE = 4'b0001 << addr_q[1:0];
          MEM_DI = {4{wdata_q[7:0]}};
        end
        SZ_H: begin
          MEM_BE = addr_q[1] ? 4'b1100 : 4'b0011;
          MEM_DI = {2{wdata_q[15:0]}};
        end
        default: begin
          MEM_BE = 4'b1111;
          MEM_DI = wdata_q;
        end
      endcase
    end
  end

  assign RESP_VALID = (state_q == ST_RESP);
  assign RESP_RDATA = rdata_q;
  assign RESP_ERR   = err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end between the multi-cycle CPU datapath and the single-port word SRAM model. Accepts one byte-addressed load or store request at a time and converts it to a word-addressed SRAM access with byte enables and lane-replicated write data. For loads, it waits out the SRAM's one-cycle read latency, then extracts and sign- or zero-extends the addressed lane. Misaligned requests are rejected without touching memory.

## Interface
- AWIDTH, 12: SRAM word-address width; must match the SRAM instance.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  unit idle; the request is accepted on an edge where VALID and READY are both high.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  zero-extend loads; ignored for stores and words.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, right-aligned.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_RDATA  out  32  load result; 0 for stores and errors.
- RESP_ERR  out  1  misaligned or illegal size; valid with RESP_VALID.
- MEM_CSN  out  1  SRAM chip select, active low.
- MEM_WEN  out  1  SRAM write enable, active low.
- MEM_ADDR  out  AWIDTH  SRAM word address.
- MEM_BE  out  4  SRAM byte enables.
- MEM_DI  out  32  SRAM write data.
- MEM_DOUT  in  32  SRAM read data; valid one cycle after the access cycle.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- Request register:
  - Captures WE, SIZE, UNSIGNED, ADDR and WDATA on acceptance.
  - All MEM_* outputs derive only from the state and request registers; there is no combinational path from REQ_* to MEM_*.
- Alignment check on acceptance:
  - ERR = (SIZE==11) | (SIZE==01 & ADDR[0]) | (SIZE==10 & ADDR[1:0]!=0).
  - On error: next state is RESP with ERR=1; the SRAM is never selected.
- Transitions:
  - IDLE -> ACCESS on accept with no error.
  - ACCESS -> RESP for stores; ACCESS -> WAIT for loads.
  - WAIT -> RESP.
  - RESP -> IDLE.
- MEM_CSN = 0 only in ACCESS and only while RST is low.
- MEM_WEN = ~WE in ACCESS; 1 in every other state.
- MEM_ADDR = ADDR[AWIDTH+1:2]; upper address bits are ignored, so addresses alias modulo 4·2^AWIDTH bytes.
- MEM_BE:
  - Byte: 1 << ADDR[1:0].
  - Half: ADDR[1] ? 1100 : 0011.
  - Word: 1111.
  - 0000 outside ACCESS.
- MEM_DI:
  - Byte: WDATA[7:0] replicated ×4.
  - Half: WDATA[15:0] replicated ×2.
  - Word: WDATA.
  - 0 outside ACCESS.
- Load extraction, registered at the end of WAIT:
  - Select the lane by ADDR[1:0] (byte) or ADDR[1] (half).
  - Sign-extend unless UNSIGNED is set.
- REQ_READY = (state==IDLE) & ~RST.
- RESP_VALID is high exactly in RESP. There is no back-pressure; the CPU samples the response in that cycle.
- RESP_RDATA and RESP_ERR hold their values until the next response.

## Timing
- Cycle 0 is the cycle whose ending edge accepts the request.
- Store: ACCESS in cycle 1 (SRAM writes at its end); RESP_VALID in cycle 2.
- Load: ACCESS in cycle 1, WAIT in cycle 2 (MEM_DOUT sampled at its end), RESP_VALID in cycle 3.
- Error: RESP_VALID with ERR=1 in cycle 1.
- Earliest next acceptance is the cycle after RESP. REQ_READY is low in ACCESS, WAIT and RESP.
- Reset values:
  - State IDLE; request register 0.
  - MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_DI=0.
  - RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0.
  - REQ_READY=0 while RST is high, 1 in the first cycle after.
- Reset mid-operation aborts in every state with no response. A store in ACCESS during a cycle with RST high must not write, because MEM_CSN is gated by RST.

## Structure
- Package mem_pkg holds:
  - SIZE encodings (SZ_B, SZ_H, SZ_W).
  - FSM state enum.
  - The misalignment function.
- Sub-module mem_load_align: combinational lane select and extension (inputs: word, addr[1:0], size, unsigned). The FSM stays in mem_access_unit.
- The bench instantiates SP_SRAM as the memory, with AWIDTH=12.

## Test plan
- Byte loads: preload word 1 = 0x8081_7F80.
  - LB 0x5 -> 0x0000007F.
  - LB 0x4 -> 0xFFFFFF80.
  - LBU 0x4 -> 0x00000080.
  - Each RESP_VALID lands exactly 3 cycles after acceptance.
- Half store then word load: SH 0x6, WDATA 0x0000BEEF.
  - In ACCESS: MEM_ADDR=1, MEM_BE=1100, MEM_DI=0xBEEFBEEF, MEM_WEN=0.
  - Response 2 cycles after acceptance.
  - Following LW 0x4 -> 0xBEEF7F80.
- Misaligned: LH 0x3 and LW 0x6.
  - Each gives RESP_ERR=1 in cycle 1, RESP_RDATA=0.
  - MEM_CSN stays 1 throughout.
  - SIZE=11 behaves the same way.
- Reset during a store: SW 0x8 with 0xDEADBEEF, RST high in ACCESS.
  - MEM_CSN=1 that cycle; no RESP_VALID.
  - Word 2 unchanged.
  - REQ_READY=1 in the first cycle after RST falls.
- Back-to-back with REQ_VALID held high: LW 0x0 then LW 0x4.
  - REQ_READY low for 3 cycles; second acceptance in the cycle after the first RESP.
  - Aliasing: LW 0x4004 returns the same data as LW 0x4.
